// File: rtl/sr_pkg.sv
// Shared definitions for the SR line-buffer write side: bank count, mode bits, FSM encoding.
package sr_pkg;
    localparam int NBANK     = 3;
    localparam int MODE_WIN3 = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_STALL = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_t;

    // Next bank in the ring, wrapping at NBANK-1
    function automatic logic [1:0] bank_next(input logic [1:0] idx);
        return (idx == 2'(NBANK - 1)) ? 2'd0 : idx + 2'd1;
    endfunction
endpackage

// File: rtl/sr_bank_occ.sv
// Up/down count of full line-buffer banks; flags reflect the count after this cycle.
// Underflow is a combinational strobe for a release seen while no bank is full.
module sr_bank_occ
    import sr_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [1:0] o_cnt,
    output logic [1:0] o_cnt_nxt,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_underflow
);
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic       w_dec_ok;

    assign w_dec_ok = i_dec & (r_cnt != 2'd0);

    // Coincident increment and decrement cancel out
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr)
            w_cnt_nxt = 2'd0;
        else if (i_inc & ~w_dec_ok & (r_cnt != 2'(NBANK)))
            w_cnt_nxt = r_cnt + 2'd1;
        else if (w_dec_ok & ~i_inc)
            w_cnt_nxt = r_cnt - 2'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= 2'd0;
        else
            r_cnt <= w_cnt_nxt;
    end

    assign o_cnt       = r_cnt;
    assign o_cnt_nxt   = w_cnt_nxt;
    assign o_full      = (w_cnt_nxt == 2'(NBANK));
    assign o_empty     = (w_cnt_nxt == 2'd0);
    assign o_underflow = i_dec & (r_cnt == 2'd0);
endmodule

// File: rtl/sr_wbank_ctrl.sv
// Write-side scheduler for the 3-bank SR line buffer: all outputs registered, one cycle after the triggering beat/release.
// Backpressure: wready drops on the row-complete beat that fills the ring or ends the frame; it returns after a release.
module sr_wbank_ctrl
    import sr_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST,
    input  logic       data_sop_i,
    input  logic       data_vld_i,
    input  logic [5:0] pic_size_i,
    input  logic [3:0] mode_i,
    input  logic       rbank_release_i,
    output logic       wready_o,
    output logic       wbank_update_o,
    output logic [1:0] wbank_idx_o,
    output logic [1:0] bank_full_cnt_o,
    output logic       rwin_vld_o,
    output logic       frame_done_o,
    output logic       err_o
);
    wr_state_t       r_state;
    logic            r_wready;
    logic            r_update;
    logic            r_frame_done;
    logic            r_err;
    logic            r_rwin_vld;
    logic            r_mode_win3;
    logic [1:0]      r_idx;
    logic [5:0]      r_pic_size;
    logic [CW-1:0]   r_beat_cnt;
    logic [CW-1:0]   r_row_cnt;

    logic [CW-1:0]   w_row_len;
    logic            w_acc;
    logic            w_row_done;
    logic            w_last_row;
    logic            w_drop;
    logic            w_win3_nxt;
    logic [1:0]      w_occ_cnt;
    logic [1:0]      w_occ_nxt;
    logic            w_occ_full;
    logic            w_occ_empty;
    logic            w_occ_underflow;
    logic            w_unused_mode;

    assign w_unused_mode = ^{mode_i[3:1], w_occ_nxt};

    // The sop beat itself is never written; gen_waddr restarts on it
    assign w_row_len  = CW'({r_pic_size, 3'b000});
    assign w_acc      = data_vld_i & r_wready & ~data_sop_i;
    assign w_row_done = w_acc & (r_beat_cnt == w_row_len - CW'(1));
    assign w_last_row = (r_row_cnt == CW'(r_pic_size) - CW'(1));
    assign w_drop     = data_vld_i & ~r_wready & ~data_sop_i &
                        ((r_state == ST_WRITE) | (r_state == ST_STALL));
    assign w_win3_nxt = data_sop_i ? mode_i[MODE_WIN3] : r_mode_win3;

    sr_bank_occ u_occ (
        .i_clk       (SYS_CLK),
        .i_rst       (SYS_RST),
        .i_clr       (data_sop_i),
        .i_inc       (w_row_done),
        .i_dec       (rbank_release_i),
        .o_cnt       (w_occ_cnt),
        .o_cnt_nxt   (w_occ_nxt),
        .o_full      (w_occ_full),
        .o_empty     (w_occ_empty),
        .o_underflow (w_occ_underflow)
    );

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_state      <= ST_IDLE;
            r_wready     <= 1'b0;
            r_update     <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_rwin_vld   <= 1'b0;
            r_mode_win3  <= 1'b0;
            r_idx        <= 2'd0;
            r_pic_size   <= 6'd0;
            r_beat_cnt   <= '0;
            r_row_cnt    <= '0;
        end else begin
            r_update     <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_occ_underflow | w_drop)
                r_err <= 1'b1;
            r_rwin_vld <= w_win3_nxt ? w_occ_full : ~w_occ_empty;

            if (data_sop_i) begin
                // Frame start or abort: restart the frame from bank 0
                r_pic_size  <= pic_size_i;
                r_mode_win3 <= mode_i[MODE_WIN3];
                r_beat_cnt  <= '0;
                r_row_cnt   <= '0;
                r_idx       <= 2'd0;
                if (pic_size_i == 6'd0) begin
                    r_state  <= ST_DONE;
                    r_wready <= 1'b0;
                end else begin
                    r_state  <= ST_WRITE;
                    r_wready <= 1'b1;
                end
            end else begin
                if (w_acc)
                    r_beat_cnt <= r_beat_cnt + CW'(1);
                if (w_row_done) begin
                    r_beat_cnt <= '0;
                    r_row_cnt  <= r_row_cnt + CW'(1);
                    r_idx      <= bank_next(r_idx);
                    r_update   <= 1'b1;
                end
                case (r_state)
                    ST_IDLE: r_state <= ST_IDLE;
                    ST_WRITE: begin
                        if (w_row_done & w_last_row) begin
                            r_state  <= ST_DONE;
                            r_wready <= 1'b0;
                        end else if (w_row_done & w_occ_full) begin
                            r_state  <= ST_STALL;
                            r_wready <= 1'b0;
                        end
                    end
                    ST_STALL: begin
                        if (~w_occ_full) begin
                            r_state  <= ST_WRITE;
                            r_wready <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign wready_o        = r_wready;
    assign wbank_update_o  = r_update;
    assign wbank_idx_o     = r_idx;
    assign bank_full_cnt_o = w_occ_cnt;
    assign rwin_vld_o      = r_rwin_vld;
    assign frame_done_o    = r_frame_done;
    assign err_o           = r_err;
endmodule

// File: tb/tb_sr_wbank_ctrl.sv
// Bench for sr_wbank_ctrl: directed frames plus random traffic against a behavioural model and output scoreboard.
module tb_sr_wbank_ctrl;
    logic       SYS_CLK = 1'b0;
    logic       SYS_RST = 1'b1;
    logic       data_sop_i = 1'b0;
    logic       data_vld_i = 1'b0;
    logic [5:0] pic_size_i = 6'd0;
    logic [3:0] mode_i = 4'd0;
    logic       rbank_release_i = 1'b0;
    logic       wready_o;
    logic       wbank_update_o;
    logic [1:0] wbank_idx_o;
    logic [1:0] bank_full_cnt_o;
    logic       rwin_vld_o;
    logic       frame_done_o;
    logic       err_o;

    always #5 SYS_CLK = ~SYS_CLK;

    sr_wbank_ctrl dut (
        .SYS_CLK         (SYS_CLK),
        .SYS_RST         (SYS_RST),
        .data_sop_i      (data_sop_i),
        .data_vld_i      (data_vld_i),
        .pic_size_i      (pic_size_i),
        .mode_i          (mode_i),
        .rbank_release_i (rbank_release_i),
        .wready_o        (wready_o),
        .wbank_update_o  (wbank_update_o),
        .wbank_idx_o     (wbank_idx_o),
        .bank_full_cnt_o (bank_full_cnt_o),
        .rwin_vld_o      (rwin_vld_o),
        .frame_done_o    (frame_done_o),
        .err_o           (err_o)
    );

    typedef struct packed {
        logic       wr;
        logic       upd;
        logic [1:0] idx;
        logic [1:0] occ;
        logic       rwin;
        logic       fd;
        logic       err;
    } exp_t;

    exp_t       q_exp[$];
    logic [3:0] q_upd[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 writing, 2 waiting for a free bank, 3 frame finishing
    int m_phase, m_beats, m_rows, m_psz, m_occ, m_idx;
    bit m_win3, m_err, m_upd, m_fd, m_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit   acc, row_done, rel_ok;
        exp_t e;
        if (SYS_RST) begin
            m_phase = 0; m_beats = 0; m_rows = 0; m_psz = 0; m_occ = 0; m_idx = 0;
            m_win3 = 0; m_err = 0; m_upd = 0; m_fd = 0; m_wr = 0;
        end else begin
            m_upd = 0;
            m_fd  = 0;
            acc = data_vld_i && m_wr && !data_sop_i;
            if (data_vld_i && !m_wr && !data_sop_i && (m_phase == 1 || m_phase == 2))
                m_err = 1;
            rel_ok = rbank_release_i && (m_occ > 0);
            if (rbank_release_i && m_occ == 0)
                m_err = 1;
            if (data_sop_i) begin
                m_psz = int'(pic_size_i); m_win3 = mode_i[0];
                m_beats = 0; m_rows = 0; m_occ = 0; m_idx = 0;
                m_wr = (pic_size_i != 0);
                m_phase = m_wr ? 1 : 3;
            end else begin
                row_done = acc && (m_beats == m_psz * 8 - 1);
                m_beats  = row_done ? 0 : m_beats + int'(acc);
                if (row_done) begin
                    m_rows++;
                    m_idx = (m_idx + 1) % 3;
                    m_upd = 1;
                end
                m_occ = m_occ + int'(row_done) - int'(rel_ok);
                if (m_phase == 1 && row_done) begin
                    if (m_rows == m_psz) begin m_phase = 3; m_wr = 0; end
                    else if (m_occ == 3) begin m_phase = 2; m_wr = 0; end
                end else if (m_phase == 2 && m_occ < 3) begin
                    m_phase = 1; m_wr = 1;
                end else if (m_phase == 3) begin
                    m_fd = 1; m_phase = 0;
                end
            end
        end
        e.wr = m_wr; e.upd = m_upd; e.idx = 2'(m_idx); e.occ = 2'(m_occ);
        e.rwin = m_win3 ? (m_occ >= 3) : (m_occ >= 1);
        e.fd = m_fd; e.err = m_err;
        q_exp.push_back(e);
        if (m_upd)
            q_upd.push_back({2'(m_idx), 2'(m_occ)});
    endtask

    task automatic cyc(input bit sop, input bit vld, input bit rel);
        data_sop_i = sop;
        data_vld_i = vld;
        rbank_release_i = rel;
        model_step();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic do_reset();
        SYS_RST = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        SYS_RST = 1'b0;
    endtask

    // Streams beats; each update is answered by a release rdly cycles later (rdly 0 = never)
    task automatic stream(input int n, input int rdly);
        bit [7:0] sh = '0;
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, (rdly > 0) ? sh[rdly-1] : 1'b0);
            sh = {sh[6:0], m_upd};
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] u;
        forever begin
            @(negedge SYS_CLK);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("wready",     wready_o,        e.wr);
                chk("update",     wbank_update_o,  e.upd);
                chk("wbank_idx",  wbank_idx_o,     e.idx);
                chk("full_cnt",   bank_full_cnt_o, e.occ);
                chk("rwin_vld",   rwin_vld_o,      e.rwin);
                chk("frame_done", frame_done_o,    e.fd);
                chk("err",        err_o,           e.err);
            end
            if (wbank_update_o === 1'b1) begin
                if (q_upd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL upd_event at %0t: got update pulse expected none", $time);
                end else begin
                    u = q_upd.pop_front();
                    chk("upd_event_idx", wbank_idx_o, u[3:2]);
                    chk("upd_event_occ", bank_full_cnt_o, u[1:0]);
                end
            end
        end
    end

    initial begin : driver
        // Two-row frame, releases trailing each update
        do_reset();
        pic_size_i = 6'd2; mode_i = 4'd0;
        cyc(1, 0, 0);
        stream(45, 3);

        // Window mode: one-row frame, then five-row frame that fills the ring
        do_reset();
        pic_size_i = 6'd1; mode_i = 4'd1;
        cyc(1, 0, 0);
        stream(12, 0);
        pic_size_i = 6'd5;
        cyc(1, 0, 0);
        stream(30, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        stream(60, 2);

        // Release lands on the beat that completes a row with two banks full
        do_reset();
        pic_size_i = 6'd4; mode_i = 4'd0;
        cyc(1, 0, 0);
        for (int i = 0; i < 140; i++)
            cyc(0, 1, (m_wr && m_beats == m_psz * 8 - 1 && m_occ == 2));

        // Abort mid-row then restart the frame
        do_reset();
        pic_size_i = 6'd2; mode_i = 4'd0;
        cyc(1, 0, 0);
        stream(5, 0);
        cyc(1, 1, 0);
        stream(40, 2);

        // Release with nothing full; error must stay set
        do_reset();
        cyc(0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);

        // Reset during stall, then an empty frame
        do_reset();
        pic_size_i = 6'd4; mode_i = 4'd0;
        cyc(1, 0, 0);
        stream(105, 0);
        SYS_RST = 1'b1;
        cyc(0, 1, 0);
        SYS_RST = 1'b0;
        pic_size_i = 6'd0;
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0);

        // Random traffic; inputs wiggle outside sop to exercise latching
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            pic_size_i = 6'($urandom_range(0, 4));
            mode_i     = 4'($urandom);
            SYS_RST    = ($urandom_range(0, 599) == 0);
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 9) < 8),
                ($urandom_range(0, 99) < 12));
        end
        SYS_RST = 1'b0;
        cyc(0, 0, 0);

        @(negedge SYS_CLK);
        #1;
        chk("exp_queue_drained", q_exp.size(), 0);
        chk("upd_queue_drained", q_upd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
